// File: rtl/mult_arbiter.sv
// Two-requester front end for one shared signed 8x8 multiplier.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; winner and operands captured on exit
// START | m_start pulsed to the multiplier
// BUSY  | waiting for m_done; product captured into result
// RESP  | one-cycle ack to the granted requester
module mult_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic [7:0]  a0,
   input  logic [7:0]  b0,
   input  logic        req1,
   input  logic [7:0]  a1,
   input  logic [7:0]  b1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] result,
   output logic        busy,
   output logic        m_start,
   output logic [7:0]  m_a,
   output logic [7:0]  m_b,
   input  logic [15:0] m_result,
   input  logic        m_done
);

   typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

   state_t state;
   state_t state_nxt;
   logic   grant;
   logic   any_req;
   logic   pick1;

   assign any_req = req0 | req1;

`ifdef MULT_ARB_RR_EN
   // last_served = 1 after reset so requester 0 wins the first tie
   logic last_served;

   always_comb begin
      pick1 = req1 & (~req0 | ~last_served);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_served <= 1'b1;
      end else if (state == RESP) begin
         last_served <= grant;
      end
   end
`else
   always_comb begin
      pick1 = req1 & ~req0;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = START;
         START:   state_nxt = BUSY;
         BUSY:    if (m_done) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operands and grant only load on leaving IDLE, so they hold through RESP
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant  <= 1'b0;
         m_a    <= 8'h00;
         m_b    <= 8'h00;
         result <= 16'h0000;
      end else begin
         if (state == IDLE && any_req) begin
            grant <= pick1;
            m_a   <= pick1 ? a1 : a0;
            m_b   <= pick1 ? b1 : b0;
         end
         if (state == BUSY && m_done) begin
            result <= m_result;
         end
      end
   end

   assign m_start = (state == START);
   assign busy    = (state != IDLE);
   assign ack0    = (state == RESP) & ~grant;
   assign ack1    = (state == RESP) & grant;

endmodule
